agc_gain_update: RTL and testbench
==================================

Name: agc_gain_update

Overview:
- Downstream stage of the AGC exponential-average level filter.
- Consumes the 48-bit averaged level (32 fractional bits) and its valid strobe.
- Compares the level against a target and updates an unsigned gain word with attack/hold/decay dynamics, clamped to min/max.
- The gain word feeds the AGC multiplier. Throughput is one update per clock.

Parameters:
- IWIDTH, 48, width of the averaged-level input.
- FRAC_SHIFT, 14, right shift that converts the level from Q.32 to Q.18 fraction.
- LWIDTH, 27, width of the working level and target (Q.18, non-negative).
- GWIDTH, 18, gain width, unsigned Q2.16 (1.0 = 65536).
- TARGET, 65536, target level in Q.18 (0.25).
- DEADBAND, 256, |error| at or below this value produces no gain change.
- ATTACK_SHIFT, 2, arithmetic right shift applied to the error during attack.
- DECAY_SHIFT, 6, arithmetic right shift applied to the error during decay.
- HOLD_LEN, 16, number of positive-error updates ignored after an attack.
- GAIN_INIT, 65536, gain value after reset.
- GAIN_MIN, 1024, lower gain clamp.
- GAIN_MAX, 262143, upper gain clamp.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ema_level  in  IWIDTH  signed averaged level, Q.32 fraction.
- ema_valid  in  1  ema_level is valid this cycle.
- freeze  in  1  while high, updates are consumed but gain is held.
- gain_out  out  GWIDTH  current gain, Q2.16.
- gain_valid  out  1  one-cycle strobe; gain_out has been refreshed.
- agc_state  out  3  encoded FSM state.

Behaviour:
- Reset values: gain_out = GAIN_INIT, gain_valid = 0, agc_state = IDLE, hold counter = 0, all pipeline valids = 0. Reset has priority over every other input and aborts any in-flight update.
- Stage 1 (cycle n+1, registered when ema_valid is high at n):
  - shifted = ema_level >>> FRAC_SHIFT.
  - If shifted < 0, level = 0.
  - Else if any bit of shifted at or above LWIDTH is set, level = 2^LWIDTH − 1.
  - Else level = shifted[LWIDTH-1:0].
  - err = TARGET − level, LWIDTH+1 bits signed.
- Stage 2 (cycle n+2): decision plus gain register update. The single-cycle feedback allows back-to-back updates.
  - freeze = 1: gain and hold counter unchanged, state unchanged, gain_valid still pulses.
  - |err| ≤ DEADBAND: state LOCK, gain unchanged, hold counter unchanged.
  - err < −DEADBAND: state ATTACK, gain += (err >>> ATTACK_SHIFT) (negative step), hold counter = HOLD_LEN.
  - err > DEADBAND with hold counter > 0: state HOLD, hold counter −1, gain unchanged.
  - err > DEADBAND with hold counter = 0: state DECAY, gain += (err >>> DECAY_SHIFT).
  - The sum is formed in GWIDTH+LWIDTH+2 signed bits, then clamped to [GAIN_MIN, GAIN_MAX]. No wrap-around is allowed.
- Output register: gain_out and agc_state are updated at n+2, and gain_valid = 1 for exactly that cycle. Latency is ema_valid(n) → gain_valid(n+2).
- With no ema_valid, all outputs hold and gain_valid = 0.
- agc_state encoding: IDLE=0, LOCK=1, ATTACK=2, HOLD=3, DECAY=4. IDLE is left on the first update after reset and never re-entered except via reset.
- Same-cycle ATTACK and hold expiry: ATTACK wins and the counter reloads.

Decomposition:
- Shared package agc_pkg holds:
  - the state enum and its encoding;
  - the Q-format constants (Q.32 level, Q.18 working, Q2.16 gain, FRAC_SHIFT = 14);
  - the gain unity constant 65536.
- One sub-module, agc_level_sat: stage 1 shift/saturate/error logic, combinational core with a registered output.

Test Plan:
- Reset: assert reset for 3 cycles → gain_out = 65536, gain_valid = 0, agc_state = 0. No output activity until the first ema_valid.
- Lock: ema_level = 65536<<14, one valid → 2 cycles later gain_valid = 1, gain_out = 65536, agc_state = LOCK.
- Attack: ema_level = 131072<<14 (err = −65536) → gain_out = 49152, state ATTACK, hold = 16.
- Hold and decay: after the attack above, 17 back-to-back valids with ema_level = 0 (err = +65536):
  - first 16 updates → HOLD, gain stays 49152;
  - 17th update → DECAY, gain = 50176.
- Clamping and saturation:
  - repeated ema_level = 2^46 (level saturates to 2^27−1) → gain decreases to 1024 and stays there;
  - ema_level negative (bit 47 set) repeatedly → level 0, gain rises to 262143 and never exceeds it.
- Freeze and reset mid-operation:
  - freeze = 1 during an attack input → gain unchanged, gain_valid still pulses;
  - reset asserted the cycle after ema_valid → no gain_valid, gain_out = 65536.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared constants and state encoding for the AGC gain-update path.
package agc_pkg;

  // Q-format bookkeeping: level arrives as Q.32, is worked on as Q.18,
  // gain is unsigned Q2.16.
  localparam int Q_LEVEL_FRAC = 32;
  localparam int Q_WORK_FRAC  = 18;
  localparam int Q_GAIN_FRAC  = 16;
  localparam int FRAC_SHIFT   = Q_LEVEL_FRAC - Q_WORK_FRAC;

  localparam int GAIN_UNITY   = 65536;

  localparam int AGC_IWIDTH       = 48;
  localparam int AGC_LWIDTH       = 27;
  localparam int AGC_GWIDTH       = 18;
  localparam int AGC_TARGET       = 65536;
  localparam int AGC_DEADBAND     = 256;
  localparam int AGC_ATTACK_SHIFT = 2;
  localparam int AGC_DECAY_SHIFT  = 6;
  localparam int AGC_HOLD_LEN     = 16;
  localparam int AGC_GAIN_INIT    = GAIN_UNITY;
  localparam int AGC_GAIN_MIN     = 1024;
  localparam int AGC_GAIN_MAX     = 262143;

  typedef enum logic [2:0] {
    AGC_IDLE   = 3'd0,
    AGC_LOCK   = 3'd1,
    AGC_ATTACK = 3'd2,
    AGC_HOLD   = 3'd3,
    AGC_DECAY  = 3'd4
  } agc_state_e;

endpackage

// File: rtl/agc_level_sat.sv
// First pipeline stage: rescale the averaged level to Q.18, saturate it to
// the non-negative working range and register the error against target.
module agc_level_sat
  import agc_pkg::*;
#(
  parameter int IWIDTH     = AGC_IWIDTH,
  parameter int FSHIFT     = FRAC_SHIFT,
  parameter int LWIDTH     = AGC_LWIDTH,
  parameter int TARGET     = AGC_TARGET
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IWIDTH-1:0]        ema_level,
  input  logic                     ema_valid,
  input  logic                     freeze,
  output logic signed [LWIDTH:0]   err,
  output logic                     err_valid,
  output logic                     err_freeze
);

  localparam logic signed [LWIDTH:0] TARGET_W = (LWIDTH+1)'(TARGET);

  logic signed [IWIDTH-1:0] shifted;
  logic [LWIDTH-1:0]        level;
  logic signed [LWIDTH:0]   err_next;

  // Shift to Q.18, clamp negatives to zero and oversize values to full scale.
  always_comb begin
    shifted = $signed(ema_level) >>> FSHIFT;
    if (shifted[IWIDTH-1]) begin
      level = '0;
    end else if (|shifted[IWIDTH-1:LWIDTH]) begin
      level = '1;
    end else begin
      level = shifted[LWIDTH-1:0];
    end
    err_next = TARGET_W - $signed({1'b0, level});
  end

  // Register the error; freeze travels with its sample so it applies to that update.
  always_ff @(posedge clk) begin
    if (reset) begin
      err        <= '0;
      err_valid  <= 1'b0;
      err_freeze <= 1'b0;
    end else begin
      err_valid <= ema_valid;
      if (ema_valid) begin
        err        <= err_next;
        err_freeze <= freeze;
      end
    end
  end

endmodule

// File: rtl/agc_gain_update.sv
// AGC gain update: attack/hold/decay control of the multiplier gain word.
//
// state  | meaning
// IDLE   | no update since reset
// LOCK   | error inside deadband, gain held
// ATTACK | level above target, gain stepped down, hold reloaded
// HOLD   | level below target but still inside post-attack hold
// DECAY  | level below target, gain stepped up slowly
module agc_gain_update
  import agc_pkg::*;
#(
  parameter int IWIDTH       = AGC_IWIDTH,
  parameter int FSHIFT       = FRAC_SHIFT,
  parameter int LWIDTH       = AGC_LWIDTH,
  parameter int GWIDTH       = AGC_GWIDTH,
  parameter int TARGET       = AGC_TARGET,
  parameter int DEADBAND     = AGC_DEADBAND,
  parameter int ATTACK_SHIFT = AGC_ATTACK_SHIFT,
  parameter int DECAY_SHIFT  = AGC_DECAY_SHIFT,
  parameter int HOLD_LEN     = AGC_HOLD_LEN,
  parameter int GAIN_INIT    = AGC_GAIN_INIT,
  parameter int GAIN_MIN     = AGC_GAIN_MIN,
  parameter int GAIN_MAX     = AGC_GAIN_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IWIDTH-1:0] ema_level,
  input  logic              ema_valid,
  input  logic              freeze,
  output logic [GWIDTH-1:0] gain_out,
  output logic              gain_valid,
  output logic [2:0]        agc_state
);

  localparam int SWIDTH = GWIDTH + LWIDTH + 2;
  localparam int HWIDTH = $clog2(HOLD_LEN + 1);

  localparam logic signed [LWIDTH:0]   DB_P   = (LWIDTH+1)'(DEADBAND);
  localparam logic signed [LWIDTH:0]   DB_N   = -DB_P;
  localparam logic signed [SWIDTH-1:0] GMIN_S = SWIDTH'(GAIN_MIN);
  localparam logic signed [SWIDTH-1:0] GMAX_S = SWIDTH'(GAIN_MAX);

  logic signed [LWIDTH:0]   err;
  logic                     err_valid;
  logic                     err_freeze;

  agc_state_e               state_q, state_d;
  logic [GWIDTH-1:0]        gain_q, gain_d;
  logic [HWIDTH-1:0]        hold_q, hold_d;
  logic                     gvalid_q;
  logic signed [LWIDTH:0]   step;
  logic signed [SWIDTH-1:0] sum;
  logic                     do_step;

  agc_level_sat #(
    .IWIDTH (IWIDTH),
    .FSHIFT (FSHIFT),
    .LWIDTH (LWIDTH),
    .TARGET (TARGET)
  ) u_level_sat (
    .clk        (clk),
    .reset      (reset),
    .ema_level  (ema_level),
    .ema_valid  (ema_valid),
    .freeze     (freeze),
    .err        (err),
    .err_valid  (err_valid),
    .err_freeze (err_freeze)
  );

  // Decide the next state, hold count and gain from the registered error.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step    = '0;
    do_step = 1'b0;
    if (err_valid && !err_freeze) begin
      if (err >= DB_N && err <= DB_P) begin
        state_d = AGC_LOCK;
      end else if (err < DB_N) begin
        state_d = AGC_ATTACK;
        step    = err >>> ATTACK_SHIFT;
        do_step = 1'b1;
        hold_d  = HWIDTH'(HOLD_LEN);
      end else if (hold_q != '0) begin
        state_d = AGC_HOLD;
        hold_d  = hold_q - HWIDTH'(1);
      end else begin
        state_d = AGC_DECAY;
        step    = err >>> DECAY_SHIFT;
        do_step = 1'b1;
      end
    end

    // Wide signed sum so neither a large step nor the clamp can wrap.
    sum = $signed({{(SWIDTH-GWIDTH){1'b0}}, gain_q})
        + $signed({{(SWIDTH-LWIDTH-1){step[LWIDTH]}}, step});
    gain_d = gain_q;
    if (do_step) begin
      if (sum < GMIN_S) begin
        gain_d = GWIDTH'(GAIN_MIN);
      end else if (sum > GMAX_S) begin
        gain_d = GWIDTH'(GAIN_MAX);
      end else begin
        gain_d = sum[GWIDTH-1:0];
      end
    end
  end

  // State, hold counter, gain and refresh strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= AGC_IDLE;
      hold_q   <= '0;
      gain_q   <= GWIDTH'(GAIN_INIT);
      gvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gain_q   <= gain_d;
      gvalid_q <= err_valid;
    end
  end

  assign gain_out   = gain_q;
  assign gain_valid = gvalid_q;
  assign agc_state  = state_q;

endmodule

// File: tb/tb_agc_gain_update.sv
// Bench for agc_gain_update: directed scenarios then random traffic against
// an arithmetic reference model.
module tb_agc_gain_update;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] ema_level;
  logic        ema_valid;
  logic        freeze;
  logic [17:0] gain_out;
  logic        gain_valid;
  logic [2:0]  agc_state;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  longint m_gain;
  int     m_hold;
  int     m_state;
  int     m_gv;
  bit     p_valid;
  bit     p_freeze;
  longint p_err;

  always #5 clk = ~clk;

  agc_gain_update dut (
    .clk        (clk),
    .reset      (reset),
    .ema_level  (ema_level),
    .ema_valid  (ema_valid),
    .freeze     (freeze),
    .gain_out   (gain_out),
    .gain_valid (gain_valid),
    .agc_state  (agc_state)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input int k);
    longint d;
    d = longint'(1) << k;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint level_of(input longint lvl);
    longint q;
    if (lvl < 0) return 0;
    q = lvl / 16384;
    if (q > 134217727) return 134217727;
    return q;
  endfunction

  function automatic longint clamp_gain(input longint g);
    if (g < 1024) return 1024;
    if (g > 262143) return 262143;
    return g;
  endfunction

  // Advance the model by one rising edge.
  task automatic model_clock(input bit rst, input bit v, input longint lvl, input bit frz);
    if (rst) begin
      m_gain = 65536; m_hold = 0; m_state = 0; m_gv = 0; p_valid = 0;
      return;
    end
    m_gv = p_valid ? 1 : 0;
    if (p_valid && !p_freeze) begin
      if (p_err >= -256 && p_err <= 256) begin
        m_state = 1;
      end else if (p_err < -256) begin
        m_state = 2;
        m_gain  = clamp_gain(m_gain + floor_div(p_err, 2));
        m_hold  = 16;
      end else if (m_hold > 0) begin
        m_state = 3;
        m_hold--;
      end else begin
        m_state = 4;
        m_gain  = clamp_gain(m_gain + floor_div(p_err, 6));
      end
    end
    p_valid = v;
    if (v) begin
      p_freeze = frz;
      p_err    = 65536 - level_of(lvl);
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input longint lvl, input bit frz);
    reset     = rst;
    ema_valid = v;
    ema_level = lvl[47:0];
    freeze    = frz;
    @(posedge clk);
    model_clock(rst, v, lvl, frz);
    @(negedge clk);
    check_val("gain_out",   longint'(gain_out),   m_gain);
    check_val("gain_valid", longint'(gain_valid), longint'(m_gv));
    check_val("agc_state",  longint'(agc_state),  longint'(m_state));
  endtask

  function automatic longint rand_level();
    longint r;
    int     cat;
    cat = $urandom_range(0, 5);
    r   = {$urandom(), $urandom()};
    r   = r & ((longint'(1) << 48) - 1);
    if (r >= (longint'(1) << 47)) r = r - (longint'(1) << 48);
    case (cat)
      0: return (65536 + longint'($urandom_range(0, 1200)) - 600) * 16384
                + longint'($urandom_range(0, 16383));
      1: return r;
      2: return -(longint'($urandom_range(1, 1000000)));
      3: return longint'(1) << 46;
      4: return longint'($urandom_range(0, 300000)) * 16384;
      default: return r & ((longint'(1) << 40) - 1);
    endcase
  endfunction

  initial begin
    reset = 1'b1; ema_valid = 1'b0; ema_level = '0; freeze = 1'b0;

    // reset and quiet period
    repeat (3) cycle(1, 0, 0, 0);
    check_val("rst_gain", longint'(gain_out), 65536);
    check_val("rst_gv", longint'(gain_valid), 0);
    check_val("rst_state", longint'(agc_state), 0);
    repeat (3) cycle(0, 0, 0, 0);

    // lock
    cycle(0, 1, longint'(65536) << 14, 0);
    cycle(0, 0, 0, 0);
    check_val("lock_gv", longint'(gain_valid), 1);
    check_val("lock_gain", longint'(gain_out), 65536);
    check_val("lock_state", longint'(agc_state), 1);
    cycle(0, 0, 0, 0);

    // attack
    cycle(0, 1, longint'(131072) << 14, 0);
    cycle(0, 0, 0, 0);
    check_val("attack_gain", longint'(gain_out), 49152);
    check_val("attack_state", longint'(agc_state), 2);

    // hold then decay
    for (int i = 0; i < 17; i++) cycle(0, 1, 0, 0);
    check_val("hold_gain", longint'(gain_out), 49152);
    check_val("hold_state", longint'(agc_state), 3);
    cycle(0, 0, 0, 0);
    check_val("decay_gain", longint'(gain_out), 50176);
    check_val("decay_state", longint'(agc_state), 4);

    // saturated level drives gain to the floor
    repeat (6) cycle(0, 1, longint'(1) << 46, 0);
    cycle(0, 0, 0, 0);
    check_val("min_clamp", longint'(gain_out), 1024);

    // negative level drives gain to the ceiling
    repeat (320) cycle(0, 1, -(longint'(1) << 46), 0);
    cycle(0, 0, 0, 0);
    check_val("max_clamp", longint'(gain_out), 262143);

    // freeze holds gain but still strobes
    cycle(0, 1, longint'(131072) << 14, 1);
    cycle(0, 0, 0, 0);
    check_val("freeze_gv", longint'(gain_valid), 1);
    check_val("freeze_gain", longint'(gain_out), 262143);

    // reset right after a valid aborts the update
    cycle(0, 1, longint'(131072) << 14, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_val("abort_gv", longint'(gain_valid), 0);
    check_val("abort_gain", longint'(gain_out), 65536);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst, v, frz;
      rst = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      frz = ($urandom_range(0, 9) == 0);
      cycle(rst, v, rand_level(), frz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
